// File: rtl/timer_ctrl_ckt_pkg.sv
// Shared types and constants for the countdown timer: FSM encoding, time record
// and the borrow-chain decrement used on every second tick.
package timer_pkg;

  localparam int MAX_HOUR = 11;
  localparam int MAX_MIN  = 59;
  localparam int MAX_SEC  = 59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
  } hms_t;

  function automatic logic hms_is_zero(input hms_t t);
    return (t == '0);
  endfunction

  // One-second decrement with borrow; saturates at zero so a stray tick can never wrap.
  function automatic hms_t hms_dec(input hms_t t);
    hms_t r;
    r = t;
    if (hms_is_zero(t)) begin
      r = '0;
    end else if (t.secs != 6'd0) begin
      r.secs = t.secs - 6'd1;
    end else begin
      r.secs = 6'(MAX_SEC);
      if (t.mins != 6'd0) begin
        r.mins = t.mins - 6'd1;
      end else begin
        r.mins  = 6'(MAX_MIN);
        r.hours = t.hours - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_ctrl_ckt_if.sv
// Button/display bundle between the timer core and its user (panel or testbench).
interface timer_ctrl_ckt_if;

  logic       btn_hour;
  logic       btn_min;
  logic       btn_start;
  logic       btn_clear;
  logic [3:0] hours_cur;
  logic [5:0] mins_cur;
  logic [5:0] secs_cur;
  logic       running;
  logic       alarm;

  modport master (
    output btn_hour, btn_min, btn_start, btn_clear,
    input  hours_cur, mins_cur, secs_cur, running, alarm
  );

  modport slave (
    input  btn_hour, btn_min, btn_start, btn_clear,
    output hours_cur, mins_cur, secs_cur, running, alarm
  );

endinterface

// File: rtl/timer_ctrl_ckt_sec_tick_gen.sv
// Prescaler producing a one-cycle sec_tick every TICKS_PER_SEC enabled cycles;
// the count holds while enable is low so a paused timer resumes at the same phase.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic sec_tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign sec_tick  = enable && w_at_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl_ckt.sv
// Countdown timer core: set h:m in IDLE, count down once per second in RUN,
// pause/resume, and raise alarm on reaching 00:00:00.
import timer_pkg::*;

module timer_ctrl_ckt #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  timer_ctrl_ckt_if.slave   bus
);

  state_t     r_state;
  hms_t       r_time;
  logic [3:0] r_preset_h;
  logic [5:0] r_preset_m;
  logic       r_running;
  logic       r_alarm;

  logic       w_tick;
  logic       w_pre_en;
  logic       w_pre_clr;
  hms_t       w_dec;
  hms_t       w_preset;
  logic       w_dec_zero;
  logic       w_time_zero;

  assign w_pre_en    = (r_state == ST_RUN);
  assign w_pre_clr   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_dec       = hms_dec(r_time);
  assign w_dec_zero  = hms_is_zero(w_dec);
  assign w_time_zero = hms_is_zero(r_time);
  assign w_preset    = '{hours: r_preset_h, mins: r_preset_m, secs: 6'd0};

  sec_tick_gen #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_sec_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (w_pre_en),
    .clear    (w_pre_clr),
    .sec_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_time     <= '0;
      r_preset_h <= '0;
      r_preset_m <= '0;
      r_running  <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.btn_clear) begin
            r_time <= '0;
          end else if (bus.btn_start) begin
            // Starting from 00:00:00 would finish instantly, so it is refused.
            if (!w_time_zero) begin
              r_preset_h <= r_time.hours;
              r_preset_m <= r_time.mins;
              r_state    <= ST_RUN;
              r_running  <= 1'b1;
            end
          end else begin
            if (bus.btn_hour) begin
              r_time.hours <= (r_time.hours == 4'(MAX_HOUR)) ? 4'd0 : r_time.hours + 4'd1;
            end
            if (bus.btn_min) begin
              r_time.mins <= (r_time.mins == 6'(MAX_MIN)) ? 6'd0 : r_time.mins + 6'd1;
            end
          end
        end

        ST_RUN: begin
          if (bus.btn_clear) begin
            r_time    <= w_preset;
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end else if (w_tick) begin
            // Reaching zero wins over a coincident start: the alarm must fire.
            r_time <= w_dec;
            if (w_dec_zero) begin
              r_state   <= ST_DONE;
              r_running <= 1'b0;
              r_alarm   <= 1'b1;
            end else if (bus.btn_start) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end
          end else if (bus.btn_start) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end
        end

        ST_PAUSE: begin
          if (bus.btn_clear) begin
            r_time  <= w_preset;
            r_state <= ST_IDLE;
          end else if (bus.btn_start) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end

        ST_DONE: begin
          if (bus.btn_clear || bus.btn_start) begin
            r_time  <= w_preset;
            r_state <= ST_IDLE;
            r_alarm <= 1'b0;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
          r_alarm   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hours_cur = r_time.hours;
  assign bus.mins_cur  = r_time.mins;
  assign bus.secs_cur  = r_time.secs;
  assign bus.running   = r_running;
  assign bus.alarm     = r_alarm;

endmodule

// File: tb/tb_timer_ctrl_ckt.sv
// Directed bench for timer_ctrl_ckt at 4 clocks per second; expected display state
// is queued with each stimulus step and compared after the clock edge.
module tb_timer_ctrl_ckt;

  localparam int TPS = 4;
  localparam logic [3:0] B_HOUR  = 4'b0001;
  localparam logic [3:0] B_MIN   = 4'b0010;
  localparam logic [3:0] B_START = 4'b0100;
  localparam logic [3:0] B_CLR   = 4'b1000;

  typedef struct {
    string       tag;
    logic [17:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  timer_ctrl_ckt_if bus ();

  timer_ctrl_ckt #(
    .TICKS_PER_SEC (TPS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pack(input int h, input int m, input int s,
                                       input int r, input int a);
    return {4'(h), 6'(m), 6'(s), 1'(r), 1'(a)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_state(input string tag, input int h, input int m, input int s,
                              input int r, input int a);
    exp_t e;
    e.tag = tag;
    e.val = pack(h, m, s, r, a);
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [17:0] obs;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty observed=nothing expected=queued entry");
    end else begin
      e   = sb.pop_front();
      obs = {bus.hours_cur, bus.mins_cur, bus.secs_cur, bus.running, bus.alarm};
      assert (obs === e.val) else begin
        tests_failed++;
        $display("FAIL %s observed %0d:%0d:%0d run=%b alarm=%b expected %0d:%0d:%0d run=%b alarm=%b",
                 e.tag, obs[17:14], obs[13:8], obs[7:2], obs[1], obs[0],
                 e.val[17:14], e.val[13:8], e.val[7:2], e.val[1], e.val[0]);
        $error("check %s", e.tag);
      end
      $display("[TB] %-16s h=%0d m=%0d s=%0d run=%b alarm=%b", e.tag,
               obs[17:14], obs[13:8], obs[7:2], obs[1], obs[0]);
    end
  endtask

  task automatic press(input logic [3:0] b);
    bus.btn_clear = b[3];
    bus.btn_start = b[2];
    bus.btn_min   = b[1];
    bus.btn_hour  = b[0];
    cyc(1);
    bus.btn_clear = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_min   = 1'b0;
    bus.btn_hour  = 1'b0;
  endtask

  task automatic press_chk(input logic [3:0] b, input string tag, input int h, input int m,
                           input int s, input int r, input int a);
    expect_state(tag, h, m, s, r, a);
    press(b);
    check();
  endtask

  task automatic run_chk(input int n, input string tag, input int h, input int m,
                         input int s, input int r, input int a);
    expect_state(tag, h, m, s, r, a);
    cyc(n);
    check();
  endtask

  initial begin
    bus.btn_hour  = 1'b0;
    bus.btn_min   = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_clear = 1'b0;
    rst_n         = 1'b0;
    cyc(2);
    run_chk(0, "reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Setting in IDLE: simultaneous buttons, hour wrap at 11, minute wrap at 59
    press_chk(B_HOUR | B_MIN, "both_btns", 1, 1, 0, 0, 0);
    repeat (4) press(B_HOUR);
    run_chk(0, "hour5", 5, 1, 0, 0, 0);
    repeat (6) press(B_HOUR);
    run_chk(0, "hour11", 11, 1, 0, 0, 0);
    press_chk(B_HOUR, "hour_wrap", 0, 1, 0, 0, 0);
    repeat (58) press(B_MIN);
    run_chk(0, "min59", 0, 59, 0, 0, 0);
    press_chk(B_MIN, "min_wrap", 0, 0, 0, 0, 0);
    press_chk(B_MIN, "min61", 0, 1, 0, 0, 0);

    // Full one-minute countdown into DONE
    press_chk(B_START, "start_0_01", 0, 1, 0, 1, 0);
    run_chk(3, "pre_first_tick", 0, 1, 0, 1, 0);
    run_chk(1, "first_tick", 0, 0, 59, 1, 0);
    run_chk(235, "last_second", 0, 0, 1, 1, 0);
    run_chk(1, "done", 0, 0, 0, 0, 1);
    run_chk(5, "done_hold", 0, 0, 0, 0, 1);
    press_chk(B_HOUR, "done_hour_ign", 0, 0, 0, 0, 1);
    press_chk(B_CLR, "done_clear", 0, 1, 0, 0, 0);
    press_chk(B_CLR, "idle_clear", 0, 0, 0, 0, 0);
    press_chk(B_START, "start_at_zero", 0, 0, 0, 0, 0);
    run_chk(4, "zero_hold", 0, 0, 0, 0, 0);

    // Pause/resume at 1:00 with preserved prescaler phase
    press(B_HOUR);
    press_chk(B_START, "start_1h", 1, 0, 0, 1, 0);
    run_chk(8, "two_ticks", 0, 59, 58, 1, 0);
    press_chk(B_START, "pause", 0, 59, 58, 0, 0);
    run_chk(20, "frozen", 0, 59, 58, 0, 0);
    press_chk(B_START, "resume", 0, 59, 58, 1, 0);
    run_chk(2, "resume_pre", 0, 59, 58, 1, 0);
    run_chk(1, "resume_tick", 0, 59, 57, 1, 0);
    run_chk(3, "pre_tick2", 0, 59, 57, 1, 0);
    press_chk(B_START, "start_on_tick", 0, 59, 56, 0, 0);
    press_chk(B_START, "resume2", 0, 59, 56, 1, 0);
    press_chk(B_HOUR | B_MIN, "run_btn_ign", 0, 59, 56, 1, 0);
    press_chk(B_CLR | B_START, "clr_and_start", 1, 0, 0, 0, 0);

    // Clear beats a coincident tick; clear from PAUSE
    press_chk(B_START, "start3", 1, 0, 0, 1, 0);
    run_chk(3, "pre_tick3", 1, 0, 0, 1, 0);
    press_chk(B_CLR, "clr_on_tick", 1, 0, 0, 0, 0);
    press_chk(B_START, "start4", 1, 0, 0, 1, 0);
    press_chk(B_START, "pause4", 1, 0, 0, 0, 0);
    press_chk(B_MIN, "pause_min_ign", 1, 0, 0, 0, 0);
    press_chk(B_CLR, "pause_clear", 1, 0, 0, 0, 0);

    // DONE exited by btn_start restores preset
    press_chk(B_CLR, "zero_again", 0, 0, 0, 0, 0);
    press(B_MIN);
    press_chk(B_START, "start5", 0, 1, 0, 1, 0);
    run_chk(240, "done2", 0, 0, 0, 0, 1);
    press_chk(B_START, "done_start", 0, 1, 0, 0, 0);

    // Reset mid-run at 0:30:15 with a button held
    repeat (30) press(B_MIN);
    press_chk(B_START, "start6", 0, 31, 0, 1, 0);
    run_chk(180, "at_30_15", 0, 30, 15, 1, 0);
    rst_n         = 1'b0;
    bus.btn_start = 1'b1;
    expect_state("rst_mid_run", 0, 0, 0, 0, 0);
    cyc(1);
    bus.btn_start = 1'b0;
    check();
    rst_n = 1'b1;
    press_chk(B_START, "post_rst_start", 0, 0, 0, 0, 0);
    run_chk(4, "post_rst_hold", 0, 0, 0, 0, 0);

    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_leftover observed=%0d entries expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
